// File: rtl/fifo_pkg.sv
// Shared definitions for the single-clock FIFO.
//   fifo_mode_e     : read-mode selector (standard registered read / FWFT)
//   fifo_cnt_w()    : occupancy counter width for a given depth (0..Depth)
//   fifo_params_ok(): elaboration-time legality check of the FIFO parameters
package fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  // One extra bit so the counter can hold Depth itself.
  function automatic int fifo_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit fifo_params_ok(input int dw, input int depth,
                                        input int af, input int ae,
                                        input int fwft);
    return (dw >= 1) && (depth >= 2) && ((depth & (depth - 1)) == 0) &&
           (af >= 1) && (af <= depth) && (ae >= 0) && (ae < depth) &&
           (fwft == 0 || fwft == 1);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Depth x DataWidth storage for sync_fifo.
//   i_clk       clock
//   i_wr_en     write strobe (already qualified by the FIFO control)
//   i_wr_addr   write address
//   i_wr_data   write data
//   i_rd_addr   read address (asynchronous read)
//   o_rd_data   word at i_rd_addr
// Storage is intentionally not reset.
module fifo_mem #(
  parameter int DataWidth = 16,
  parameter int Depth     = 16,
  parameter int AddrW     = $clog2(Depth)
) (
  input  logic                 i_clk,
  input  logic                 i_wr_en,
  input  logic [AddrW-1:0]     i_wr_addr,
  input  logic [DataWidth-1:0] i_wr_data,
  input  logic [AddrW-1:0]     i_rd_addr,
  output logic [DataWidth-1:0] o_rd_data
);

  logic [DataWidth-1:0] r_mem [Depth];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock parametrised FIFO with standard or first-word-fall-through read.
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_wr_en/i_wr_data push request and data (ignored while full)
//   i_rd_en           pop request (ignored while empty)
//   i_clr_err         clears the sticky error flags
//   o_rd_data/o_rd_valid  read data and qualifier
//   o_full/o_empty/o_almost_full/o_almost_empty  registered status
//   o_count           occupancy 0..Depth
//   o_overflow/o_underflow  sticky request-while-full / request-while-empty
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DataWidth         = 16,
  parameter int Depth             = 16,
  parameter int AlmostFullThresh  = 14,
  parameter int AlmostEmptyThresh = 2,
  parameter int Fwft              = 0
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_wr_en,
  input  logic [DataWidth-1:0]             i_wr_data,
  input  logic                             i_rd_en,
  input  logic                             i_clr_err,
  output logic [DataWidth-1:0]             o_rd_data,
  output logic                             o_rd_valid,
  output logic                             o_full,
  output logic                             o_empty,
  output logic                             o_almost_full,
  output logic                             o_almost_empty,
  output logic [fifo_cnt_w(Depth)-1:0]     o_count,
  output logic                             o_overflow,
  output logic                             o_underflow
);

  localparam int         AW   = $clog2(Depth);
  localparam int         CW   = fifo_cnt_w(Depth);
  localparam fifo_mode_e MODE = (Fwft != 0) ? FIFO_FWFT : FIFO_STD;

  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(Depth);
  localparam logic [CW-1:0] CNT_AF   = CW'(AlmostFullThresh);
  localparam logic [CW-1:0] CNT_AE   = CW'(AlmostEmptyThresh);

  generate
    if (!fifo_params_ok(DataWidth, Depth, AlmostFullThresh, AlmostEmptyThresh, Fwft)) begin : g_bad_params
      $error("sync_fifo: illegal parameter combination");
    end
  endgenerate

  logic [AW-1:0]        r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]        r_count, w_cnt_nxt;
  logic                 r_full, r_empty, r_afull, r_aempty;
  logic                 r_ovf, r_unf;
  logic [DataWidth-1:0] r_rd_data, w_head;
  logic                 r_rd_valid;
  logic                 w_wr_acc, w_rd_acc;

  // Requests in a reset cycle are dropped, including the memory write.
  assign w_wr_acc = i_wr_en & ~r_full  & ~i_rst;
  assign w_rd_acc = i_rd_en & ~r_empty & ~i_rst;

  fifo_mem #(.DataWidth(DataWidth), .Depth(Depth), .AddrW(AW)) u_mem (
    .i_clk     (i_clk),
    .i_wr_en   (w_wr_acc),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (i_wr_data),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_head)
  );

  always_comb begin
    w_cnt_nxt = r_count;
    if (w_wr_acc && !w_rd_acc)      w_cnt_nxt = r_count + CNT_ONE;
    else if (w_rd_acc && !w_wr_acc) w_cnt_nxt = r_count - CNT_ONE;
  end

  // Status flags are derived from the next count so they line up with o_count.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_afull    <= 1'b0;
      r_aempty   <= 1'b1;
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count    <= w_cnt_nxt;
      r_full     <= (w_cnt_nxt == CNT_FULL);
      r_empty    <= (w_cnt_nxt == '0);
      r_afull    <= (w_cnt_nxt >= CNT_AF);
      r_aempty   <= (w_cnt_nxt <= CNT_AE);
      // Set has priority over clear.
      r_ovf      <= (i_wr_en & r_full)  | (r_ovf & ~i_clr_err);
      r_unf      <= (i_rd_en & r_empty) | (r_unf & ~i_clr_err);
      r_rd_valid <= w_rd_acc;
      if (w_rd_acc) r_rd_data <= w_head;
    end
  end

  // FWFT shows the head straight from storage; it is forced to zero while
  // empty so stale or unreset storage never leaks onto the bus.
  assign o_rd_data      = (MODE == FIFO_FWFT) ? (r_empty ? '0 : w_head) : r_rd_data;
  assign o_rd_valid     = (MODE == FIFO_FWFT) ? ~r_empty : r_rd_valid;
  assign o_full         = r_full;
  assign o_empty        = r_empty;
  assign o_almost_full  = r_afull;
  assign o_almost_empty = r_aempty;
  assign o_count        = r_count;
  assign o_overflow     = r_ovf;
  assign o_underflow    = r_unf;

endmodule

// File: tb/tb_sync_fifo.sv
module tb_sync_fifo;

  localparam int DW = 8;
  localparam int D  = 8;
  localparam int AF = 6;
  localparam int AE = 1;
  localparam int CW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- standard-mode DUT ----------------
  logic          s_rst = 1'b1, s_wr = 1'b0, s_rd = 1'b0, s_clr = 1'b0;
  logic [DW-1:0] s_wd = '0;
  logic [DW-1:0] s_rdata;
  logic          s_rvalid, s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
  logic [CW-1:0] s_cnt;

  sync_fifo #(.DataWidth(DW), .Depth(D), .AlmostFullThresh(AF),
              .AlmostEmptyThresh(AE), .Fwft(0)) dut_std (
    .i_clk(clk), .i_rst(s_rst), .i_wr_en(s_wr), .i_wr_data(s_wd),
    .i_rd_en(s_rd), .i_clr_err(s_clr), .o_rd_data(s_rdata),
    .o_rd_valid(s_rvalid), .o_full(s_full), .o_empty(s_empty),
    .o_almost_full(s_af), .o_almost_empty(s_ae), .o_count(s_cnt),
    .o_overflow(s_ovf), .o_underflow(s_unf)
  );

  // ---------------- FWFT-mode DUT ----------------
  logic          f_rst = 1'b1, f_wr = 1'b0, f_rd = 1'b0, f_clr = 1'b0;
  logic [DW-1:0] f_wd = '0;
  logic [DW-1:0] f_rdata;
  logic          f_rvalid, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
  logic [CW-1:0] f_cnt;

  sync_fifo #(.DataWidth(DW), .Depth(D), .AlmostFullThresh(AF),
              .AlmostEmptyThresh(AE), .Fwft(1)) dut_fwft (
    .i_clk(clk), .i_rst(f_rst), .i_wr_en(f_wr), .i_wr_data(f_wd),
    .i_rd_en(f_rd), .i_clr_err(f_clr), .o_rd_data(f_rdata),
    .o_rd_valid(f_rvalid), .o_full(f_full), .o_empty(f_empty),
    .o_almost_full(f_af), .o_almost_empty(f_ae), .o_count(f_cnt),
    .o_overflow(f_ovf), .o_underflow(f_unf)
  );

  // ---------------- reference models (queue-based) ----------------
  logic [DW-1:0] sq[$];     // std FIFO contents
  logic [DW-1:0] s_exp[$];  // std expected read responses
  bit            m_s_valid = 0, m_s_ovf = 0, m_s_unf = 0;
  logic [DW-1:0] m_s_last = '0;

  always @(posedge clk) begin : m_std
    int n;
    bit wa, ra;
    if (s_rst) begin
      sq.delete(); s_exp.delete();
      m_s_valid = 0; m_s_last = '0; m_s_ovf = 0; m_s_unf = 0;
    end else begin
      n  = sq.size();
      wa = s_wr && (n < D);
      ra = s_rd && (n > 0);
      m_s_ovf   = (s_wr && n == D) || (m_s_ovf && !s_clr);
      m_s_unf   = (s_rd && n == 0) || (m_s_unf && !s_clr);
      m_s_valid = ra;
      if (ra) begin
        m_s_last = sq.pop_front();
        s_exp.push_back(m_s_last);
      end
      if (wa) sq.push_back(s_wd);
    end
  end

  logic [DW-1:0] fq[$];
  bit            m_f_ovf = 0, m_f_unf = 0;

  always @(posedge clk) begin : m_fwft
    int n;
    if (f_rst) begin
      fq.delete(); m_f_ovf = 0; m_f_unf = 0;
    end else begin
      n = fq.size();
      m_f_ovf = (f_wr && n == D) || (m_f_ovf && !f_clr);
      m_f_unf = (f_rd && n == 0) || (m_f_unf && !f_clr);
      if (f_rd && n > 0) void'(fq.pop_front());
      if (f_wr && n < D) fq.push_back(f_wd);
    end
  end

  // ---------------- monitor ----------------
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("s_count",    int'(s_cnt),   sq.size());
      chk("s_full",     int'(s_full),  int'(sq.size() == D));
      chk("s_empty",    int'(s_empty), int'(sq.size() == 0));
      chk("s_afull",    int'(s_af),    int'(sq.size() >= AF));
      chk("s_aempty",   int'(s_ae),    int'(sq.size() <= AE));
      chk("s_overflow", int'(s_ovf),   int'(m_s_ovf));
      chk("s_underflow",int'(s_unf),   int'(m_s_unf));
      chk("s_rd_valid", int'(s_rvalid),int'(m_s_valid));
      chk("s_rd_data_hold", int'(s_rdata), int'(m_s_last));
      if (s_rvalid) begin
        if (s_exp.size() == 0) chk("s_unexpected_valid", 1, 0);
        else                   chk("s_pop_data", int'(s_rdata), int'(s_exp.pop_front()));
      end

      chk("f_count",    int'(f_cnt),   fq.size());
      chk("f_full",     int'(f_full),  int'(fq.size() == D));
      chk("f_empty",    int'(f_empty), int'(fq.size() == 0));
      chk("f_afull",    int'(f_af),    int'(fq.size() >= AF));
      chk("f_aempty",   int'(f_ae),    int'(fq.size() <= AE));
      chk("f_overflow", int'(f_ovf),   int'(m_f_ovf));
      chk("f_underflow",int'(f_unf),   int'(m_f_unf));
      chk("f_rd_valid", int'(f_rvalid),int'(fq.size() > 0));
      if (fq.size() > 0) chk("f_head_data", int'(f_rdata), int'(fq[0]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic s_cyc(input bit w, input bit r, input logic [DW-1:0] d,
                       input bit c, input bit rs);
    s_wr = w; s_rd = r; s_wd = d; s_clr = c; s_rst = rs;
    @(negedge clk);
  endtask

  task automatic f_cyc(input bit w, input bit r, input logic [DW-1:0] d,
                       input bit c, input bit rs);
    f_wr = w; f_rd = r; f_wd = d; f_clr = c; f_rst = rs;
    @(negedge clk);
  endtask

  initial begin
    // reset both
    @(negedge clk);
    @(negedge clk);
    s_rst = 1'b0; f_rst = 1'b0;

    // fill / drain
    for (int i = 0; i < D; i++) s_cyc(1, 0, 8'($urandom), 0, 0);
    s_cyc(0, 0, 8'h00, 0, 0);
    for (int i = 0; i < D; i++) s_cyc(0, 1, 8'h00, 0, 0);
    s_cyc(0, 0, 8'h00, 0, 0);

    // thresholds
    for (int i = 1; i <= 6; i++) s_cyc(1, 0, 8'(i), 0, 0);
    for (int i = 0; i < 5; i++) s_cyc(0, 1, 8'h00, 0, 0);
    s_cyc(0, 1, 8'h00, 0, 0);
    s_cyc(0, 0, 8'h00, 0, 0);

    // overflow / underflow
    for (int i = 0; i < D + 1; i++) s_cyc(1, 0, 8'($urandom), 0, 0);
    for (int i = 0; i < 3; i++) s_cyc(0, 0, 8'h00, 0, 0);
    s_cyc(0, 0, 8'h00, 1, 0);
    for (int i = 0; i < D; i++) s_cyc(0, 1, 8'h00, 0, 0);
    s_cyc(0, 1, 8'h00, 0, 0);
    for (int i = 0; i < 2; i++) s_cyc(0, 0, 8'h00, 0, 0);
    s_cyc(0, 0, 8'h00, 1, 0);
    s_cyc(0, 0, 8'h00, 0, 0);

    // simultaneous traffic at count 4
    for (int i = 0; i < 4; i++) s_cyc(1, 0, 8'($urandom), 0, 0);
    for (int i = 0; i < 20; i++) s_cyc(1, 1, 8'($urandom), 0, 0);
    for (int i = 0; i < 4; i++) s_cyc(0, 1, 8'h00, 0, 0);
    s_cyc(0, 0, 8'h00, 0, 0);

    // reset mid-stream
    for (int i = 0; i < 5; i++) s_cyc(1, 0, 8'($urandom), 0, 0);
    s_cyc(1, 0, 8'($urandom), 0, 1);
    s_cyc(1, 0, 8'h3C, 0, 0);
    s_cyc(0, 1, 8'h00, 0, 0);
    for (int i = 0; i < 2; i++) s_cyc(0, 0, 8'h00, 0, 0);

    // randomized traffic: write-heavy then read-heavy
    for (int i = 0; i < 400; i++) begin
      int pw, pr;
      pw = (i < 200) ? 70 : 40;
      pr = (i < 200) ? 40 : 70;
      s_cyc(($urandom_range(99) < pw), ($urandom_range(99) < pr), 8'($urandom),
            ($urandom_range(99) < 5), ($urandom_range(199) == 0));
    end
    for (int i = 0; i < D + 2; i++) s_cyc(0, 1, 8'h00, 0, 0);
    s_cyc(0, 0, 8'h00, 0, 0);

    // FWFT: single word falls through, one read empties it
    f_cyc(1, 0, 8'hA5, 0, 0);
    f_cyc(0, 0, 8'h00, 0, 0);
    f_cyc(0, 1, 8'h00, 0, 0);
    for (int i = 0; i < 2; i++) f_cyc(0, 0, 8'h00, 0, 0);

    for (int i = 0; i < 400; i++) begin
      int pw, pr;
      pw = (i < 200) ? 70 : 40;
      pr = (i < 200) ? 40 : 70;
      f_cyc(($urandom_range(99) < pw), ($urandom_range(99) < pr), 8'($urandom),
            ($urandom_range(99) < 5), ($urandom_range(199) == 0));
    end
    for (int i = 0; i < D + 2; i++) f_cyc(0, 1, 8'h00, 0, 0);
    f_cyc(0, 0, 8'h00, 0, 0);

    @(posedge clk);
    #1;
    chk("s_exp_drained", s_exp.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
